// File: rtl/evb1005_capture_if.sv
// Sensor pixel port and host pipe-out port of the EVB1005 frame-capture block.
// The master side is the board environment (sensor and host), the slave side is the controller.
interface evb1005_capture_if;
    logic        pix_en;
    logic        frame_valid;
    logic        line_valid;
    logic [11:0] pix_data;
    logic        po_read;
    logic [15:0] po_data;

    modport master (
        output pix_en,
        output frame_valid,
        output line_valid,
        output pix_data,
        output po_read,
        input  po_data
    );

    modport slave (
        input  pix_en,
        input  frame_valid,
        input  line_valid,
        input  pix_data,
        input  po_read,
        output po_data
    );
endinterface

// File: rtl/evb1005_capture.sv
// EVB1005 frame-capture controller: grabs one full sensor frame into a word FIFO
// on a host trigger and drains it through a first-word-fall-through pipe-out port.
module evb1005_capture #(
    parameter int unsigned FIFO_DEPTH = 8192,
    parameter int unsigned READY_HOLD = 16
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic [15:0]         ctrl,
    input  logic                trig_capture,
    evb1005_capture_if.slave    bus,
    output logic [15:0]         fifo_count,
    output logic [15:0]         status,
    output logic                reset_b,
    output logic                trigger,
    output logic [7:0]          led
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(READY_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_END,
        S_CAPTURE
    } state_t;

    state_t              state_q, state_n;
    logic                fv_q;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic                ready_n, busy_n, done_n, ovf_n, udf_n;
    logic                trigger_n;
    logic                wr_en, push, pop, avail, full;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next, used;
    logic                po_valid_q;
    logic [15:0]         po_data_q;
    logic [15:0]         mem [FIFO_DEPTH];

    logic soft_rst, fifo_clr, ctrl_busy, pix_wr, fv_rise, fv_fall, trig_ok;
    logic ctrl_unused;

    assign soft_rst    = ctrl[0];
    assign fifo_clr    = ctrl[2];
    assign ctrl_busy   = |ctrl[3:0];
    assign ctrl_unused = ^ctrl[15:4];
    assign pix_wr      = bus.frame_valid & bus.line_valid & bus.pix_en;
    assign fv_rise     = bus.frame_valid & ~fv_q;
    assign fv_fall     = ~bus.frame_valid & fv_q;
    assign trig_ok     = trig_capture & status[0] & ~ctrl_busy;
    assign used        = wr_ptr - rd_ptr;
    assign full        = (used == PTR_W'(FIFO_DEPTH));
    assign bus.po_data = po_data_q;

    // Next-state, ready hold-off, sticky flags and FIFO handshake decode
    always_comb begin
        state_n   = state_q;
        trigger_n = 1'b0;
        hold_n    = hold_q;
        done_n    = status[2];
        ovf_n     = status[3];
        udf_n     = status[4];
        wr_en     = 1'b0;

        if (ctrl_busy) begin
            hold_n = '0;
        end else if (hold_q != HOLD_W'(READY_HOLD)) begin
            hold_n = hold_q + HOLD_W'(1);
        end
        ready_n = ~ctrl_busy & (hold_n == HOLD_W'(READY_HOLD));

        case (state_q)
            S_IDLE: begin
                if (trig_ok) begin
                    state_n   = S_ARMED;
                    trigger_n = 1'b1;
                    done_n    = 1'b0;
                    ovf_n     = 1'b0;
                end
            end
            S_ARMED: begin
                // A rising frame_valid is a true frame start; already-high means mid-frame
                if (fv_rise) begin
                    state_n = S_CAPTURE;
                    wr_en   = pix_wr;
                end else if (bus.frame_valid) begin
                    state_n = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (!bus.frame_valid) begin
                    state_n = S_ARMED;
                end
            end
            S_CAPTURE: begin
                wr_en = pix_wr;
                if (fv_fall) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);

        push = wr_en & ~fifo_clr & ~full;
        if (wr_en & ~fifo_clr & full) begin
            ovf_n = 1'b1;
        end

        // Only a word already visible on po_data may be popped
        pop = bus.po_read & po_valid_q & ~fifo_clr;
        if (bus.po_read & ~po_valid_q) begin
            udf_n = 1'b1;
        end

        rd_next = rd_ptr + PTR_W'(pop);
        avail   = (wr_ptr != rd_next);
    end

    // FIFO storage, written only while capturing
    always_ff @(posedge clk1) begin
        if (push & ~soft_rst) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {4'b0, bus.pix_data};
        end
    end

    // State, flags, FIFO pointers and registered outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fv_q       <= 1'b0;
            hold_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            po_valid_q <= 1'b0;
            po_data_q  <= '0;
            fifo_count <= '0;
            status     <= '0;
            reset_b    <= 1'b0;
            trigger    <= 1'b0;
            led        <= 8'hFF;
        end else begin
            reset_b <= ~ctrl[1];
            fv_q    <= bus.frame_valid;
            if (soft_rst) begin
                state_q    <= S_IDLE;
                hold_q     <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                po_valid_q <= 1'b0;
                po_data_q  <= '0;
                fifo_count <= '0;
                status     <= '0;
                trigger    <= 1'b0;
                led        <= 8'hFF;
            end else begin
                state_q <= state_n;
                hold_q  <= hold_n;
                trigger <= trigger_n;
                status  <= {11'b0, udf_n, ovf_n, done_n, busy_n, ready_n};
                led     <= ~{4'b0, ovf_n, done_n, busy_n, ready_n};
                if (fifo_clr) begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    po_valid_q <= 1'b0;
                    po_data_q  <= '0;
                    fifo_count <= '0;
                end else begin
                    wr_ptr     <= wr_ptr + PTR_W'(push);
                    rd_ptr     <= rd_next;
                    po_valid_q <= avail;
                    po_data_q  <= avail ? mem[rd_next[ADDR_W-1:0]] : 16'h0000;
                    fifo_count <= (32'(used) > 32'h0000_FFFF) ? 16'hFFFF : 16'(used);
                end
            end
        end
    end

endmodule

// File: tb/tb_evb1005_capture.sv
// Bench for evb1005_capture: directed sensor frames and host accesses, with a
// pipe-out scoreboard and a second instance sized 4096 words for the overflow case.
module tb_evb1005_capture;

    localparam int unsigned HOLD = 16;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic [15:0] ctrl;
    logic        trig_capture;
    logic [15:0] fifo_count, status, fifo_count_o, status_o;
    logic        reset_b, trigger, reset_b_o, trigger_o;
    logic [7:0]  led, led_o;

    evb1005_capture_if bus ();
    evb1005_capture_if bus_o ();

    assign bus_o.pix_en      = bus.pix_en;
    assign bus_o.frame_valid = bus.frame_valid;
    assign bus_o.line_valid  = bus.line_valid;
    assign bus_o.pix_data    = bus.pix_data;

    evb1005_capture #(.FIFO_DEPTH(8192), .READY_HOLD(HOLD)) dut (
        .clk1(clk1), .rst_n(rst_n), .ctrl(ctrl), .trig_capture(trig_capture), .bus(bus),
        .fifo_count(fifo_count), .status(status), .reset_b(reset_b), .trigger(trigger), .led(led)
    );

    evb1005_capture #(.FIFO_DEPTH(4096), .READY_HOLD(HOLD)) dut_o (
        .clk1(clk1), .rst_n(rst_n), .ctrl(ctrl), .trig_capture(trig_capture), .bus(bus_o),
        .fifo_count(fifo_count_o), .status(status_o), .reset_b(reset_b_o), .trigger(trigger_o), .led(led_o)
    );

    always #5 clk1 = ~clk1;

    int          vectors = 0;
    int          miscompares = 0;
    int          trig_seen = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pipe-out monitor: every sampled read strobe consumes one expected word
    always @(negedge clk1) begin
        if (trigger === 1'b1) trig_seen++;
        if (bus.po_read === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL po_data: read with no expected word, got 0x%0h", bus.po_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (bus.po_data !== exp_word) begin
                    miscompares++;
                    $display("FAIL po_data: got 0x%0h, expected 0x%0h", bus.po_data, exp_word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic sensor_cycle(input logic fv, input logic lv, input logic pe,
                                input logic [11:0] px, input int c, input int ta, input int tb);
        bus.frame_valid = fv;
        bus.line_valid  = lv;
        bus.pix_en      = pe;
        bus.pix_data    = px;
        trig_capture    = (c == ta) || (c == tb);
        tick();
    endtask

    // 80x60 frame, pixel k = k mod 4096; one pix_en gap per line; optional trigger pulses at cycle ta/tb
    task automatic send_frame(input int ta, input int tb);
        int c = 0;
        int k = 0;
        for (int i = 0; i < 3; i++) sensor_cycle(1'b1, 1'b0, 1'b0, 12'h000, c++, ta, tb);
        for (int ln = 0; ln < 60; ln++) begin
            for (int p = 0; p < 80; p++) begin
                if (p == 40) sensor_cycle(1'b1, 1'b1, 1'b0, 12'hABC, c++, ta, tb);
                sensor_cycle(1'b1, 1'b1, 1'b1, 12'(k), c++, ta, tb);
                k++;
            end
            for (int i = 0; i < 4; i++) sensor_cycle(1'b1, 1'b0, 1'b0, 12'h000, c++, ta, tb);
        end
        for (int i = 0; i < 2; i++) sensor_cycle(1'b1, 1'b0, 1'b0, 12'h000, c++, ta, tb);
        for (int i = 0; i < 6; i++) sensor_cycle(1'b0, 1'b0, 1'b0, 12'h000, c++, ta, tb);
        trig_capture = 1'b0;
    endtask

    task automatic drain(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(16'(first + i));
            bus.po_read = 1'b1;
            tick();
        end
        bus.po_read = 1'b0;
    endtask

    task automatic pulse_trig();
        trig_capture = 1'b1;
        tick();
        trig_capture = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ctrl = 16'h000F;
        trig_capture = 1'b0;
        bus.pix_en = 1'b0;
        bus.frame_valid = 1'b0;
        bus.line_valid = 1'b0;
        bus.pix_data = 12'h000;
        bus.po_read = 1'b0;
        bus_o.po_read = 1'b0;

        @(negedge clk1);
        chk("rst po_data", 32'(bus.po_data), 32'h0);
        chk("rst fifo_count", 32'(fifo_count), 32'h0);
        chk("rst status", 32'(status), 32'h0);
        chk("rst trigger", 32'(trigger), 32'h0);
        chk("rst reset_b", 32'(reset_b), 32'h0);
        chk("rst led", 32'(led), 32'hFF);

        // Reset sequence 0xF, 0xE, 0xC, 0x8, 0x0
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk1);
        chk("ctrl F reset_b", 32'(reset_b), 32'h0);
        tick();
        ctrl = 16'h000E;
        repeat (3) tick();
        pulse_trig();
        tick();
        @(negedge clk1);
        chk("ctrl E reset_b", 32'(reset_b), 32'h0);
        chk("ctrl E status", 32'(status), 32'h0);
        tick();
        ctrl = 16'h000C;
        repeat (3) tick();
        @(negedge clk1);
        chk("ctrl C reset_b", 32'(reset_b), 32'h1);
        tick();
        ctrl = 16'h0008;
        repeat (3) tick();
        @(negedge clk1);
        chk("ctrl 8 status", 32'(status), 32'h0);
        tick();
        ctrl = 16'h0000;
        repeat (HOLD - 1) tick();
        @(negedge clk1);
        chk("hold-1 status", 32'(status), 32'h0);
        tick();
        @(negedge clk1);
        chk("ready status", 32'(status), 32'h0001);
        chk("ready led", 32'(led), 32'hFE);
        chk("trig while not ready", 32'(trig_seen), 32'd0);

        // Trigger mid-frame: that frame is skipped, the next is captured
        tick();
        send_frame(1000, -1);
        send_frame(-1, -1);
        repeat (4) tick();
        @(negedge clk1);
        chk("frame count", 32'(fifo_count), 32'd4800);
        chk("frame status", 32'(status), 32'h0005);
        chk("frame led", 32'(led), 32'hFA);
        chk("frame head", 32'(bus.po_data), 32'h0);
        chk("frame trig pulses", 32'(trig_seen), 32'd1);
        chk("ovf count", 32'(fifo_count_o), 32'd4096);
        chk("ovf status", 32'(status_o), 32'h000D);

        // Partial drain of 128 bytes
        tick();
        drain(64, 0);
        repeat (3) tick();
        @(negedge clk1);
        chk("drain count", 32'(fifo_count), 32'd4736);
        chk("drain head", 32'(bus.po_data), 32'h0040);

        // FIFO clear leaves flags alone
        tick();
        ctrl = 16'h0004;
        tick();
        ctrl = 16'h0000;
        tick();
        @(negedge clk1);
        chk("clear count", 32'(fifo_count), 32'h0);
        chk("clear status", 32'(status), 32'h0004);
        tick();
        repeat (HOLD + 2) tick();
        @(negedge clk1);
        chk("clear ready status", 32'(status), 32'h0005);

        // Extra triggers during capture are ignored
        tick();
        pulse_trig();
        tick();
        @(negedge clk1);
        chk("armed status", 32'(status), 32'h0003);
        chk("armed ovf status", 32'(status_o), 32'h0003);
        tick();
        send_frame(500, 2500);
        repeat (4) tick();
        @(negedge clk1);
        chk("busy trig count", 32'(fifo_count), 32'd4800);
        chk("busy trig status", 32'(status), 32'h0005);
        chk("busy trig pulses", 32'(trig_seen), 32'd2);
        chk("busy ovf count", 32'(fifo_count_o), 32'd4096);
        chk("busy ovf status", 32'(status_o), 32'h000D);
        tick();
        drain(4, 0);
        repeat (3) tick();
        @(negedge clk1);
        chk("busy drain count", 32'(fifo_count), 32'd4796);

        // Soft reset in the middle of a capture
        tick();
        pulse_trig();
        tick();
        fork
            send_frame(-1, -1);
            begin
                repeat (1500) @(posedge clk1);
                #1 ctrl = 16'h0001;
                @(posedge clk1);
                @(posedge clk1);
                @(negedge clk1);
                chk("srst count", 32'(fifo_count), 32'h0);
                chk("srst status", 32'(status), 32'h0);
                chk("srst po_data", 32'(bus.po_data), 32'h0);
                chk("srst led", 32'(led), 32'hFF);
                @(posedge clk1);
                #1 ctrl = 16'h0000;
            end
        join
        repeat (4) tick();
        @(negedge clk1);
        chk("post srst count", 32'(fifo_count), 32'h0);
        chk("post srst status", 32'(status), 32'h0001);
        chk("post srst pulses", 32'(trig_seen), 32'd3);

        // Read from an empty FIFO
        tick();
        exp_q.push_back(16'h0000);
        bus.po_read = 1'b1;
        tick();
        bus.po_read = 1'b0;
        tick();
        @(negedge clk1);
        chk("underflow status", 32'(status), 32'h0011);
        chk("underflow led", 32'(led), 32'hFE);
        chk("underflow count", 32'(fifo_count), 32'h0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/evb1005_capture.md
# evb1005_capture

Frame-capture controller for the EVB1005 camera board. It sits between the image-sensor pixel port and the host pipe-out endpoint. Software triggers it to grab exactly one full frame of 12-bit pixels into an on-chip word FIFO, then drains the FIFO through a first-word-fall-through pipe interface. Host wire-ins and wire-outs appear as plain ports: reset/control word (0x00), FIFO count (0x20), status (0x21), capture trigger (0x40) and pipe-out (0xA0).

## Interface
Parameters:
- `FIFO_DEPTH`, default 8192: FIFO depth in 16-bit words. Power of two, at least 4800 (one 80x60 frame).
- `READY_HOLD`, default 16: clk1 cycles from reset release to assertion of `ready`.

Ports:
- `clk1`  in  1  system clock, 100 MHz. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ctrl`  in  16  wire-in 0x00. Bit0: soft reset. Bit1: sensor reset. Bit2: FIFO clear. Bit3: hold-off. Bits 15:4 ignored.
- `trig_capture`  in  1  trigger-in 0x40 bit0. One-cycle pulse.
- `pix_en`  in  1  pixel-clock enable; one pixel per asserted cycle.
- `frame_valid`  in  1  sensor frame valid.
- `line_valid`  in  1  sensor line valid.
- `pix_data`  in  12  sensor pixel.
- `po_read`  in  1  pipe-out 0xA0 read strobe.
- `po_data`  out  16  FIFO head word.
- `fifo_count`  out  16  wire-out 0x20. Number of words in FIFO, saturating at 0xFFFF.
- `status`  out  16  wire-out 0x21. Bit0 `ready`, bit1 `busy`, bit2 `frame_done`, bit3 `overflow`, bit4 `underflow`. Other bits 0.
- `reset_b`  out  1  sensor reset, active-low.
- `trigger`  out  1  sensor trigger pulse.
- `led`  out  8  board LEDs, active-low: `~{4'b0, status[3:0]}`.

## Operation
- Internal reset = `~rst_n` OR `ctrl[0]`. It clears the FSM, the FIFO and all status flags.
- `reset_b` = `rst_n & ~ctrl[1]`, registered.
- `ctrl[2]` synchronously empties the FIFO, leaving flags unchanged.
- `ready` asserts `READY_HOLD` cycles after `ctrl[3:0]` becomes 0 with `rst_n` high. It drops immediately if any of `ctrl[3:0]` is set.
- Triggers are ignored while `ready` is 0.
- FSM states: IDLE, ARMED, WAIT_END, CAPTURE.
  - IDLE: `trig_capture` while `ready` goes to ARMED. On that transition, clear `frame_done` and `overflow`, and pulse `trigger` for one cycle.
  - ARMED: if `frame_valid` is 1, go to WAIT_END. If 0, go to CAPTURE on the first cycle `frame_valid` rises.
  - WAIT_END: on `frame_valid` falling, return to ARMED. This guarantees capture starts at a frame boundary.
  - CAPTURE: on each cycle with `frame_valid & line_valid & pix_en`, write `{4'b0, pix_data}` to the FIFO. On `frame_valid` falling, set `frame_done` and go to IDLE.
- Triggers outside IDLE are ignored.
- `busy` = state is not IDLE.
- FIFO is first-word-fall-through. `po_data` shows the head word whenever the FIFO is not empty, and 0 when empty.
  - `po_read` pops the head word.
  - `po_read` on an empty FIFO: no pop, `po_data` = 0, sticky `underflow` set.
- Write while full: pixel dropped, sticky `overflow` set.
- Simultaneous write and read: both take effect; count unchanged.
- Host byte order is low byte first, so byte 2k is `pix[k][7:0]` and byte 2k+1 is `{4'b0, pix[k][11:8]}`.

## Timing
- All outputs are registered.
- Values under reset: `po_data` 0, `fifo_count` 0, `status` 0, `trigger` 0, `reset_b` 0, `led` 0xFF.
- A pixel written at edge N is visible in `fifo_count` and, if the FIFO was empty, in `po_data` after edge N+1.
- The pop takes effect at the edge where `po_read` is sampled high; the next word appears on `po_data` after that edge.
- `trigger` is high for exactly the cycle after the IDLE→ARMED edge.
- `frame_done` sets one cycle after the `frame_valid` falling edge is sampled.
- Soft reset or `rst_n` asserted mid-capture: the FSM returns to IDLE, the FIFO empties and the frame is discarded.
- `ready` falls in the same cycle `ctrl[3:0]` becomes nonzero.
- Pointer arithmetic uses log2(`FIFO_DEPTH`)+1 bits; pointers wrap modulo 2·`FIFO_DEPTH`.

## Test plan
- Reset sequence: drive `ctrl` = 0xF, 0xE, 0xC, 0x8, 0x0, one wire update each. Required: `status[0]` = 0 until `READY_HOLD` cycles after `ctrl` = 0, then `status` = 0x0001. `reset_b` goes high when `ctrl[1]` clears.
- Single frame: sensor model sends 80x60 frames with incrementing pixels 0x000…; pulse `trig_capture` mid-frame. Required: that frame is skipped. The next frame fills 4800 words, word k = k mod 4096. `status` reads 0x0005 after frame end.
- Partial drain: poll until `fifo_count` ≥ 128, then read 128 bytes (64 `po_read` pulses). Required: bytes in little-endian order matching the pixel sequence, and `fifo_count` decreased by 64.
- Overflow: set `FIFO_DEPTH` = 4096, capture one 80x60 frame without draining. Required: exactly 4096 words stored, `status[3]` = 1, remaining 704 pixels lost.
- Trigger while busy: extra `trig_capture` pulses during CAPTURE. Required: no second `trigger` pulse and FIFO holds exactly one frame.
- Mid-capture soft reset: set `ctrl[0]` during CAPTURE. Required: `fifo_count` = 0, `status` = 0, FSM in IDLE. Empty-FIFO `po_read`: `po_data` = 0 and `status[4]` = 1.
